// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the convolver slave register map.
// The optional stall timeout in ahb_lite_master is enabled with AHB_MST_TIMEOUT_EN.
package ahb_pkg;

    localparam int unsigned AHB_ADDR_W = 4;
    localparam int unsigned AHB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic HSIZE_BYTE = 1'b0;
    localparam logic HSIZE_HALF = 1'b1;

    // Convolver slave register map (byte addresses)
    localparam logic [AHB_ADDR_W-1:0] REG_STATUS   = 4'h0;
    localparam logic [AHB_ADDR_W-1:0] REG_RESULT   = 4'h2;
    localparam logic [AHB_ADDR_W-1:0] REG_SAMPLE   = 4'h4;
    localparam logic [AHB_ADDR_W-1:0] REG_COEFF_R0 = 4'h6;
    localparam logic [AHB_ADDR_W-1:0] REG_COEFF_R1 = 4'h8;
    localparam logic [AHB_ADDR_W-1:0] REG_COEFF_R2 = 4'hA;
    localparam logic [AHB_ADDR_W-1:0] REG_CTRL     = 4'hC;

    // Address-phase entry; fields are kept zero while empty so they can drive the bus directly
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [AHB_ADDR_W-1:0] addr;
        logic                  size;
        logic [AHB_DATA_W-1:0] wdata;
    } aph_t;

    // Data-phase entry; wdata is zero for reads
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [AHB_DATA_W-1:0] wdata;
        logic                  err;
    } dph_t;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic                  err;
        logic [AHB_DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Request/response stream plus AHB-Lite bus between the sequencer, the master and the slave.
interface ahb_lite_master_if import ahb_pkg::*; #(
    parameter int unsigned ADDR_W = AHB_ADDR_W,
    parameter int unsigned DATA_W = AHB_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              req_size;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    htrans_t           htrans;
    logic              hsize;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;
    logic              hready;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output hsel, haddr, htrans, hsize, hwrite, hwdata,
        input  hrdata, hresp, hready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  hsel, haddr, htrans, hsize, hwrite, hwdata,
        output hrdata, hresp, hready
    );

endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready requests become pipelined NONSEQ transfers, one in-order response each.
// Define AHB_MST_TIMEOUT_EN to abort transfers after TIMEOUT_CYC consecutive hready-low cycles.
module ahb_lite_master import ahb_pkg::*; #(
    parameter int unsigned ADDR_W      = AHB_ADDR_W,
    parameter int unsigned DATA_W      = AHB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    ahb_lite_master_if.master bus
);

    aph_t aph_q, aph_d;
    dph_t dph_q, dph_d;
    rsp_t rsp_q, rsp_d;
    aph_t req_entry;
    logic req_ready_c;
    logic accept;

    // APH may take a request during a stall only while it is empty
    assign req_ready_c   = bus.hready || !aph_q.valid;
    assign accept        = bus.req_valid && req_ready_c;
    assign bus.req_ready = req_ready_c;

    always_comb begin
        req_entry       = '0;
        req_entry.valid = 1'b1;
        req_entry.write = bus.req_write;
        req_entry.addr  = AHB_ADDR_W'(bus.req_addr);
        req_entry.size  = bus.req_size;
        req_entry.wdata = bus.req_write ? AHB_DATA_W'(bus.req_wdata) : '0;
    end

`ifdef AHB_MST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // Fires on the edge that ends the TIMEOUT_CYC-th consecutive stall cycle
    assign tmo_hit = !bus.hready && (aph_q.valid || dph_q.valid)
                     && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (bus.hready || tmo_hit) begin
            tmo_d = '0;
        end else if (aph_q.valid || dph_q.valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Without the timeout a stall lasts as long as the slave holds hready low
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Pipeline advance, completion and (optionally) timeout abort
    always_comb begin
        aph_d = aph_q;
        dph_d = dph_q;
        rsp_d = '0;

        if (bus.hready) begin
            if (dph_q.valid) begin
                rsp_d.valid = 1'b1;
                rsp_d.write = dph_q.write;
                rsp_d.err   = dph_q.err;
                rsp_d.rdata = (!dph_q.write && !dph_q.err) ? AHB_DATA_W'(bus.hrdata) : '0;
            end
            dph_d = '0;
            if (aph_q.valid) begin
                dph_d.valid = 1'b1;
                dph_d.write = aph_q.write;
                dph_d.wdata = aph_q.wdata;
                dph_d.err   = bus.hresp;
            end
            aph_d = '0;
        end

`ifdef AHB_MST_TIMEOUT_EN
        if (tmo_hit) begin
            rsp_d.valid = 1'b1;
            rsp_d.write = dph_q.valid ? dph_q.write : aph_q.write;
            rsp_d.err   = 1'b1;
            rsp_d.rdata = '0;
            dph_d       = '0;
            aph_d       = '0;
        end
`endif

        if (accept) begin
            aph_d = req_entry;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            aph_q <= '0;
            dph_q <= '0;
            rsp_q <= '0;
        end else begin
            aph_q <= aph_d;
            dph_q <= dph_d;
            rsp_q <= rsp_d;
        end
    end

    // Bus and response outputs come straight from the phase/response registers
    assign bus.hsel      = aph_q.valid;
    assign bus.htrans    = aph_q.valid ? NONSEQ : IDLE;
    assign bus.haddr     = ADDR_W'(aph_q.addr);
    assign bus.hsize     = aph_q.size;
    assign bus.hwrite    = aph_q.write;
    assign bus.hwdata    = DATA_W'(dph_q.wdata);

    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_write = rsp_q.write;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_rdata = DATA_W'(rsp_q.rdata);

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: directed scenarios plus random traffic against a transfer-level model.
module tb_ahb_lite_master;
    import ahb_pkg::*;

    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned TIMEOUT_CYC = 16;

    // One accepted request; target = count of hready-high edges at which its data phase ends
    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic              size;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                target;
    } xfer_t;

    logic clk = 1'b0;
    logic n_rst;
    int   total = 0;
    int   bad   = 0;

    xfer_t             q[$];
    xfer_t             exp_x;
    bit                exp_rsp = 1'b0;
    int                hi_cnt  = 0;
    int                low_run = 0;
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] slv_mem [16];
    logic              s_dph_valid = 1'b0;
    logic              s_dph_write = 1'b0;
    logic              s_dph_err   = 1'b0;
    logic [ADDR_W-1:0] s_dph_addr  = '0;

    always #5 clk = ~clk;

    ahb_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_lite_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.master)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_eq("rst_rsp_write", 32'(bus.rsp_write), 32'h0);
        check_eq("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
        check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        check_eq("rst_hsel",      32'(bus.hsel),      32'h0);
        check_eq("rst_htrans",    32'(bus.htrans),    32'h0);
        check_eq("rst_haddr",     32'(bus.haddr),     32'h0);
        check_eq("rst_hsize",     32'(bus.hsize),     32'h0);
        check_eq("rst_hwrite",    32'(bus.hwrite),    32'h0);
        check_eq("rst_hwdata",    32'(bus.hwdata),    32'h0);
    endtask

    // Bus and response expectations for the current cycle, derived from the in-flight list
    task automatic check_outputs();
        bit    aph_f = 1'b0;
        bit    dph_f = 1'b0;
        xfer_t a;
        xfer_t d;
        foreach (q[i]) begin
            if (q[i].target == hi_cnt + 2) begin aph_f = 1'b1; a = q[i]; end
            if (q[i].target == hi_cnt + 1) begin dph_f = 1'b1; d = q[i]; end
        end
        check_eq("hsel",   32'(bus.hsel),   32'(aph_f));
        check_eq("htrans", 32'(bus.htrans), aph_f ? 32'h2 : 32'h0);
        check_eq("haddr",  32'(bus.haddr),  aph_f ? 32'(a.addr) : 32'h0);
        check_eq("hsize",  32'(bus.hsize),  aph_f ? 32'(a.size) : 32'h0);
        check_eq("hwrite", 32'(bus.hwrite), aph_f ? 32'(a.write) : 32'h0);
        check_eq("hwdata", 32'(bus.hwdata), (dph_f && d.write) ? 32'(d.wdata) : 32'h0);
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_rsp) begin
            check_eq("rsp_write", 32'(bus.rsp_write), 32'(exp_x.write));
            check_eq("rsp_err",   32'(bus.rsp_err),   32'(exp_x.err));
            check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_x.rdata));
        end
    endtask

    // One clock: check current outputs, drive request and slave inputs, advance the model over the edge
    task automatic cycle(input bit rv, input bit rw, input logic [ADDR_W-1:0] ra,
                         input bit rs, input logic [DATA_W-1:0] rd, input bit hr);
        bit                aph_full = 1'b0;
        bit                exp_ready;
        xfer_t             x;
        logic              nv;
        logic              nw;
        logic              ne;
        logic [ADDR_W-1:0] na;

        check_outputs();
        foreach (q[i]) if (q[i].target == hi_cnt + 2) aph_full = 1'b1;
        exp_ready = hr || !aph_full;

        bus.req_valid = rv;
        bus.req_write = rw;
        bus.req_addr  = ra;
        bus.req_size  = rs;
        bus.req_wdata = rd;
        bus.hready    = hr;
        bus.hresp     = bus.hsel && (bus.haddr >= 4'hE);
        bus.hrdata    = (s_dph_valid && !s_dph_write && !s_dph_err) ? slv_mem[s_dph_addr]
                                                                    : DATA_W'($urandom);
        #1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));

        nv = bus.hsel && (bus.htrans == NONSEQ);
        nw = bus.hwrite;
        na = bus.haddr;
        ne = bus.hresp;
        if (hr) begin
            if (s_dph_valid && s_dph_write && !s_dph_err) slv_mem[s_dph_addr] = bus.hwdata;
            s_dph_valid = nv;
            s_dph_write = nw;
            s_dph_addr  = na;
            s_dph_err   = ne;
            hi_cnt++;
        end

        exp_rsp = 1'b0;
        if (hr && q.size() > 0 && q[0].target == hi_cnt) begin
            exp_x   = q.pop_front();
            exp_rsp = 1'b1;
        end
        if (rv && exp_ready) begin
            x.write  = rw;
            x.addr   = ra;
            x.size   = rs;
            x.wdata  = rd;
            x.err    = (ra >= 4'hE);
            x.rdata  = (!rw && !x.err) ? ref_mem[ra] : '0;
            x.target = hi_cnt + 2;
            if (rw && !x.err) ref_mem[ra] = rd;
            q.push_back(x);
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        bit                hr;
        int                seen;
        int                seen_at;
        logic              seen_err;
        logic              seen_write;
        logic [DATA_W-1:0] seen_rdata;

        n_rst         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = 1'b0;
        bus.req_wdata = '0;
        bus.hready    = 1'b0;
        bus.hresp     = 1'b0;
        bus.hrdata    = '0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = DATA_W'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        #1;
        check_reset_vals();
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);

        // Single halfword write to COEFF_R0
        cycle(1'b1, 1'b1, 4'h6, 1'b1, 16'h1234, 1'b1);
        idle(4);

        // Write then read of SAMPLE, back to back
        cycle(1'b1, 1'b1, 4'h4, 1'b1, 16'hBEEF, 1'b1);
        cycle(1'b1, 1'b0, 4'h4, 1'b1, 16'h0000, 1'b1);
        idle(4);

        // Stall during a read data phase with APH full; offered request must be refused
        cycle(1'b1, 1'b0, 4'h6, 1'b1, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 4'h4, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0);
        cycle(1'b1, 1'b1, 4'h8, 1'b1, 16'h5A5A, 1'b0);
        idle(4);

        // Request accepted while stalled with APH empty
        cycle(1'b1, 1'b0, 4'h2, 1'b1, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0);
        idle(4);

        // Error read of 0xE followed by a clean read of STATUS
        cycle(1'b1, 1'b0, 4'hE, 1'b1, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 4'h0, 1'b1, 16'h0000, 1'b1);
        idle(4);

        // Random traffic with bounded stall runs
        for (int n = 0; n < 300; n++) begin
            hr      = ($urandom_range(0, 3) != 0) || (low_run >= 4);
            low_run = hr ? 0 : low_run + 1;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), ADDR_W'($urandom),
                  1'($urandom), DATA_W'($urandom), hr);
        end
        idle(6);

        // Reset while a read is in its data phase and another in its address phase
        cycle(1'b1, 1'b0, 4'h2, 1'b1, 16'h0000, 1'b1);
        cycle(1'b1, 1'b0, 4'hA, 1'b1, 16'h0000, 1'b1);
        n_rst      = 1'b0;
        bus.hready = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        exp_rsp     = 1'b0;
        s_dph_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        idle(5);
        cycle(1'b1, 1'b0, 4'h4, 1'b1, 16'h0000, 1'b1);
        idle(4);

`ifdef AHB_MST_TIMEOUT_EN
        // Write whose data phase stalls 20 cycles: abort after the 16th
        seen       = 0;
        seen_at    = -1;
        seen_err   = 1'b0;
        seen_write = 1'b0;
        seen_rdata = '1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 4'h6;
        bus.req_size  = 1'b1;
        bus.req_wdata = 16'hCAFE;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        bus.hrdata    = 16'hFFFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("to_dph_hwdata", 32'(bus.hwdata), 32'h0000CAFE);
        bus.hready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen++;
                seen_at    = i;
                seen_err   = bus.rsp_err;
                seen_write = bus.rsp_write;
                seen_rdata = bus.rsp_rdata;
            end
        end
        check_eq("to_rsp_count", 32'(seen),       32'd1);
        check_eq("to_rsp_cycle", 32'(seen_at),    32'd16);
        check_eq("to_rsp_err",   32'(seen_err),   32'h1);
        check_eq("to_rsp_write", 32'(seen_write), 32'h1);
        check_eq("to_rsp_rdata", 32'(seen_rdata), 32'h0);
        check_eq("to_htrans",    32'(bus.htrans), 32'h0);
        check_eq("to_hsel",      32'(bus.hsel),   32'h0);
        check_eq("to_hwdata",    32'(bus.hwdata), 32'h0);
        bus.hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check_eq("to_no_late_rsp", 32'(seen), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
